// File: rtl/blink_checker_if.sv
// rtl/blink_checker_if.sv - blink monitor bus: LED input, start pulse and sticky verdict outputs.
interface blink_checker_if #(
    parameter int unsigned WIDTH = 8
);
    logic [WIDTH-1:0] blink;
    logic             start;
    logic             busy;
    logic             pass;
    logic             fail;
    logic             timeout;
    logic [7:0]       good_cnt;
    logic [31:0]      fail_period;

    modport master (
        output blink, start,
        input  busy, pass, fail, timeout, good_cnt, fail_period
    );

    modport slave (
        input  blink, start,
        output busy, pass, fail, timeout, good_cnt, fail_period
    );
endinterface

// File: rtl/blink_checker.sv
// rtl/blink_checker.sv - toggle-interval monitor on one blink bit with sticky pass/fail/timeout.
// Optional failing-interval capture into fail_period under macro BLINK_CHK_CAPTURE_EN.
module blink_checker #(
    parameter int unsigned WIDTH     = 8,
    parameter int unsigned CHK_BIT   = 0,
    parameter int unsigned EXPECT    = 1000,
    parameter int unsigned TOL       = 2,
    parameter int unsigned REQ_EDGES = 4,
    parameter int unsigned TIMEOUT   = 550000
) (
    input  logic         clk,
    input  logic         rst,
    blink_checker_if.slave bus
);
    localparam logic [31:0] LO       = (TOL >= EXPECT) ? 32'd1 : 32'(EXPECT - TOL);
    localparam logic [31:0] HI       = 32'(EXPECT + TOL);
    localparam logic [31:0] LATE     = 32'(EXPECT + TOL + 1);
    localparam logic [31:0] TMO_LAST = 32'(TIMEOUT - 1);
    localparam logic [8:0]  REQ      = 9'(REQ_EDGES);

    typedef enum logic [1:0] {
        S_IDLE,
        S_ARM,
        S_MEASURE
    } state_t;

    state_t      r_state;
    logic        r_sync1;
    logic        r_sync2;
    logic        r_hist;
    logic [31:0] r_ivl;
    logic [31:0] r_tmo;
    logic [7:0]  r_good_cnt;
    logic        r_busy;
    logic        r_pass;
    logic        r_fail;
    logic        r_timeout;

    logic        w_edge;
    logic        w_in_tol;
    logic [8:0]  w_good_next;
    logic        w_unused_bits;

    // blink is asynchronous to clk; only the monitored bit is synchronised
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_sync1 <= 1'b0;
            r_sync2 <= 1'b0;
            r_hist  <= 1'b0;
        end else begin
            r_sync1 <= bus.blink[CHK_BIT];
            r_sync2 <= r_sync1;
            r_hist  <= r_sync2;
        end
    end

    assign w_edge        = r_sync2 ^ r_hist;
    assign w_in_tol      = (r_ivl >= LO) && (r_ivl <= HI);
    assign w_good_next   = {1'b0, r_good_cnt} + 9'd1;
    assign w_unused_bits = ^bus.blink;

`ifdef BLINK_CHK_CAPTURE_EN
    logic [31:0] r_fail_period;
    assign bus.fail_period = r_fail_period;
`else
    assign bus.fail_period = 32'd0;
`endif

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state    <= S_IDLE;
            r_ivl      <= 32'd0;
            r_tmo      <= 32'd0;
            r_good_cnt <= 8'd0;
            r_busy     <= 1'b0;
            r_pass     <= 1'b0;
            r_fail     <= 1'b0;
            r_timeout  <= 1'b0;
`ifdef BLINK_CHK_CAPTURE_EN
            r_fail_period <= 32'd0;
`endif
        end else begin
            if (bus.start) begin
                r_ivl <= 32'd0;
            end else if (w_edge) begin
                r_ivl <= 32'd1;
            end else if (r_ivl != 32'hFFFF_FFFF) begin
                r_ivl <= r_ivl + 32'd1;
            end

            // start overrides any edge or decision landing in the same cycle
            if (bus.start) begin
                r_state    <= S_ARM;
                r_busy     <= 1'b1;
                r_tmo      <= 32'd0;
                r_good_cnt <= 8'd0;
                r_pass     <= 1'b0;
                r_fail     <= 1'b0;
                r_timeout  <= 1'b0;
`ifdef BLINK_CHK_CAPTURE_EN
                r_fail_period <= 32'd0;
`endif
            end else begin
                case (r_state)
                    S_ARM: begin
                        r_tmo <= r_tmo + 32'd1;
                        if (w_edge) begin
                            r_state <= S_MEASURE;
                        end else if (r_tmo >= TMO_LAST) begin
                            r_timeout <= 1'b1;
                            r_busy    <= 1'b0;
                            r_state   <= S_IDLE;
                        end
                    end
                    S_MEASURE: begin
                        if (w_edge && w_in_tol) begin
                            if (r_good_cnt != 8'hFF) begin
                                r_good_cnt <= w_good_next[7:0];
                            end
                            if (w_good_next == REQ) begin
                                r_pass  <= 1'b1;
                                r_busy  <= 1'b0;
                                r_state <= S_IDLE;
                            end
                        end else if ((w_edge && (r_ivl < LO)) || (r_ivl >= LATE)) begin
                            // late intervals fail at LATE without waiting for the edge
                            r_fail  <= 1'b1;
                            r_busy  <= 1'b0;
                            r_state <= S_IDLE;
`ifdef BLINK_CHK_CAPTURE_EN
                            r_fail_period <= r_ivl;
`endif
                        end
                    end
                    default: begin
                        r_state <= S_IDLE;
                    end
                endcase
            end
        end
    end

    assign bus.busy     = r_busy;
    assign bus.pass     = r_pass;
    assign bus.fail     = r_fail;
    assign bus.timeout  = r_timeout;
    assign bus.good_cnt = r_good_cnt;
endmodule

// File: tb/tb_blink_checker.sv
// tb/tb_blink_checker.sv - directed bench for blink_checker (EXPECT 1000, TOL 2, REQ 4, TIMEOUT 500).
module tb_blink_checker;
    logic clk;
    logic rst;
    int   n_vec;
    int   n_bad;

`ifdef BLINK_CHK_CAPTURE_EN
    localparam logic [31:0] FP_EARLY = 32'd997;
    localparam logic [31:0] FP_LATE  = 32'd1003;
`else
    localparam logic [31:0] FP_EARLY = 32'd0;
    localparam logic [31:0] FP_LATE  = 32'd0;
`endif

    blink_checker_if #(.WIDTH(8)) bus ();

    blink_checker #(
        .WIDTH(8), .CHK_BIT(0), .EXPECT(1000), .TOL(2), .REQ_EDGES(4), .TIMEOUT(500)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic pulse_start();
        bus.start = 1'b1;
        tick(1);
        bus.start = 1'b0;
    endtask

    // toggle bit 0 n clocks after the previous drive point, optionally scrambling bits 7:1
    task automatic toggle(input int n, input bit noisy);
        for (int i = 0; i < n; i++) begin
            tick(1);
            if (noisy) bus.blink[7:1] = 7'($urandom);
        end
        bus.blink[0] = ~bus.blink[0];
    endtask

    task automatic check_flags(input string tag, input logic [31:0] b, input logic [31:0] p,
                               input logic [31:0] f, input logic [31:0] t, input logic [31:0] g);
        check({tag, ".busy"},     32'(bus.busy),     b);
        check({tag, ".pass"},     32'(bus.pass),     p);
        check({tag, ".fail"},     32'(bus.fail),     f);
        check({tag, ".timeout"},  32'(bus.timeout),  t);
        check({tag, ".good_cnt"}, 32'(bus.good_cnt), g);
    endtask

    initial begin
        n_vec     = 0;
        n_bad     = 0;
        rst       = 1'b0;
        bus.blink = 8'h00;
        bus.start = 1'b0;
        tick(3);
        check_flags("reset", 0, 0, 0, 0, 0);
        check("reset.fail_period", bus.fail_period, 32'd0);
        rst = 1'b1;
        tick(2);

        // 1: four 1000-clk intervals pass
        pulse_start();
        check("t1.busy_arm", 32'(bus.busy), 32'd1);
        toggle(3, 1'b0);
        for (int i = 0; i < 4; i++) toggle(1000, 1'b0);
        tick(2);
        check_flags("t1.pre", 1, 0, 0, 0, 3);
        tick(1);
        check_flags("t1.post", 0, 1, 0, 0, 4);

        // 2: early edge at 997
        pulse_start();
        check_flags("t2.start", 1, 0, 0, 0, 0);
        toggle(3, 1'b0);
        toggle(1000, 1'b0);
        toggle(1000, 1'b0);
        toggle(997, 1'b0);
        tick(2);
        check("t2.pre_fail", 32'(bus.fail), 32'd0);
        tick(1);
        check_flags("t2.post", 0, 0, 1, 0, 2);
        check("t2.fail_period", bus.fail_period, FP_EARLY);

        // 3: bit held after one good interval, fail at 1003
        pulse_start();
        check("t3.fail_cleared", 32'(bus.fail), 32'd0);
        toggle(3, 1'b0);
        toggle(1000, 1'b0);
        tick(1005);
        check_flags("t3.pre", 1, 0, 0, 0, 1);
        tick(1);
        check_flags("t3.post", 0, 0, 1, 0, 1);
        check("t3.fail_period", bus.fail_period, FP_LATE);

        // 4: no edge, timeout after 500 clk in ARM
        pulse_start();
        tick(499);
        check_flags("t4.pre", 1, 0, 0, 0, 0);
        tick(1);
        check_flags("t4.post", 0, 0, 0, 1, 0);

        // 5a: restart mid-MEASURE, then a clean pass
        pulse_start();
        check("t5.tmo_cleared", 32'(bus.timeout), 32'd0);
        toggle(3, 1'b0);
        toggle(1000, 1'b0);
        toggle(1000, 1'b0);
        tick(3);
        check("t5.good2", 32'(bus.good_cnt), 32'd2);
        pulse_start();
        check_flags("t5.restart", 1, 0, 0, 0, 0);
        toggle(3, 1'b0);
        for (int i = 0; i < 4; i++) toggle(1000, 1'b0);
        tick(3);
        check_flags("t5.pass", 0, 1, 0, 0, 4);

        // 5b: asynchronous reset mid-MEASURE
        pulse_start();
        toggle(3, 1'b0);
        toggle(1000, 1'b0);
        tick(10);
        check("t5b.good1", 32'(bus.good_cnt), 32'd1);
        rst = 1'b0;
        #1;
        check_flags("t5b.rst", 0, 0, 0, 0, 0);
        check("t5b.fail_period", bus.fail_period, 32'd0);
        tick(2);
        rst = 1'b1;
        tick(5);

        // 6: 1002/998 intervals with noise on bits 7:1
        pulse_start();
        toggle(3, 1'b1);
        for (int i = 0; i < 4; i++) toggle((i % 2 == 0) ? 1002 : 998, 1'b1);
        tick(2);
        check_flags("t6.pre", 1, 0, 0, 0, 3);
        tick(1);
        check_flags("t6.post", 0, 1, 0, 0, 4);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end
endmodule
